// File: rtl/craft_stream_loader.sv
// Stream front end for the CRAFT core: gathers 8 input words into key/tweak/plaintext,
// holds the core in reset for two cycles, waits for done and returns the ciphertext as two words.
module craft_stream_loader #(
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [31:0]  s_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [31:0]  m_data,
   output logic         core_rst_n,
   output logic [63:0]  core_plaintext,
   output logic [63:0]  core_tweak,
   output logic [127:0] core_key,
   input  logic         core_done,
   input  logic [63:0]  core_ciphertext,
   output logic         busy,
   output logic         err
);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {LOAD, PRIME, RUN, OUT_HI, OUT_LO} state_t;

   state_t         state, state_nx;
   logic [2:0]     widx;
   logic           prime_cnt;
   logic [CW-1:0]  to_cnt;
   logic [63:0]    ct_q;
   logic           s_fire;
   logic           to_hit;

   assign s_fire = s_valid && s_ready;
   assign to_hit = (to_cnt == CW'(TIMEOUT - 1));
   assign busy   = (state != LOAD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LOAD;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      s_ready    = 1'b0;
      m_valid    = 1'b0;
      m_data     = '0;
      core_rst_n = 1'b0;
      case (state)
         LOAD: begin
            s_ready = !rst;
            if (s_valid && widx == 3'd7) state_nx = PRIME;
         end
         PRIME: begin
            if (prime_cnt) state_nx = RUN;
         end
         RUN: begin
            core_rst_n = 1'b1;
            if (core_done)   state_nx = OUT_HI;
            else if (to_hit) state_nx = LOAD;
         end
         OUT_HI: begin
            core_rst_n = 1'b1;
            m_valid    = 1'b1;
            m_data     = ct_q[63:32];
            if (m_ready) state_nx = OUT_LO;
         end
         OUT_LO: begin
            core_rst_n = 1'b1;
            m_valid    = 1'b1;
            m_data     = ct_q[31:0];
            if (m_ready) state_nx = LOAD;
         end
         default: state_nx = LOAD;
      endcase
   end

   // widx wraps 7 -> 0 on the final word, ready for the next block
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         widx           <= '0;
         prime_cnt      <= 1'b0;
         to_cnt         <= '0;
         ct_q           <= '0;
         err            <= 1'b0;
         core_key       <= '0;
         core_tweak     <= '0;
         core_plaintext <= '0;
      end else begin
         if (s_fire) begin
            widx <= widx + 3'd1;
            case (widx)
               3'd0: core_key[127:96]     <= s_data;
               3'd1: core_key[95:64]      <= s_data;
               3'd2: core_key[63:32]      <= s_data;
               3'd3: core_key[31:0]       <= s_data;
               3'd4: core_tweak[63:32]    <= s_data;
               3'd5: core_tweak[31:0]     <= s_data;
               3'd6: core_plaintext[63:32] <= s_data;
               default: core_plaintext[31:0] <= s_data;
            endcase
         end
         prime_cnt <= (state == PRIME) ? ~prime_cnt : 1'b0;
         to_cnt    <= (state == RUN) ? to_cnt + 1'b1 : '0;
         if (state == RUN && core_done)            ct_q <= core_ciphertext;
         if (state == RUN && !core_done && to_hit) err  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_craft_stream_loader.sv
// Directed bench for craft_stream_loader with a behavioural stand-in for the CRAFT core
// and a scoreboard queue of expected output words.
module tb_craft_stream_loader;
   logic         clk = 1'b0;
   logic         rst;
   logic         s_valid;
   logic [31:0]  s_data;
   logic         m_ready;
   logic         sel_to;

   logic         s_ready, m_valid, core_rst_n, busy, err, core_done;
   logic [31:0]  m_data;
   logic [63:0]  core_plaintext, core_tweak, core_ciphertext;
   logic [127:0] core_key;

   logic         t_s_ready, t_m_valid, t_core_rst_n, t_busy, t_err;
   logic [31:0]  t_m_data;
   logic [63:0]  t_core_plaintext, t_core_tweak;
   logic [127:0] t_core_key;

   logic         main_s_valid, t_s_valid;
   logic [5:0]   ccnt;
   logic         t_mv_seen;

   int           total  = 0;
   int           passed = 0;
   logic [31:0]  sb_q[$];

   always #5 clk = ~clk;

   assign main_s_valid = s_valid & ~sel_to;
   assign t_s_valid    = s_valid & sel_to;

   craft_stream_loader dut (
      .clk(clk), .rst(rst),
      .s_valid(main_s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .core_rst_n(core_rst_n), .core_plaintext(core_plaintext),
      .core_tweak(core_tweak), .core_key(core_key),
      .core_done(core_done), .core_ciphertext(core_ciphertext),
      .busy(busy), .err(err)
   );

   craft_stream_loader #(.TIMEOUT(8)) u_to (
      .clk(clk), .rst(rst),
      .s_valid(t_s_valid), .s_ready(t_s_ready), .s_data(s_data),
      .m_valid(t_m_valid), .m_ready(m_ready), .m_data(t_m_data),
      .core_rst_n(t_core_rst_n), .core_plaintext(t_core_plaintext),
      .core_tweak(t_core_tweak), .core_key(t_core_key),
      .core_done(1'b0), .core_ciphertext(64'h0),
      .busy(t_busy), .err(t_err)
   );

   // Stand-in cipher: any mix that depends on every input bit will do for this front end
   function automatic logic [63:0] cipher(input logic [127:0] k, input logic [63:0] t,
                                          input logic [63:0] p);
      return ({p[31:0], p[63:32]} ^ k[127:64]) + (k[63:0] ^ t);
   endfunction

   // Core model: synchronous active-low reset, done after 32 running cycles, then frozen
   always_ff @(posedge clk) begin
      if (!core_rst_n) begin
         ccnt            <= '0;
         core_done       <= 1'b0;
         core_ciphertext <= '0;
      end else if (!core_done) begin
         ccnt <= ccnt + 6'd1;
         if (ccnt == 6'd31) begin
            core_done       <= 1'b1;
            core_ciphertext <= cipher(core_key, core_tweak, core_plaintext);
         end
      end
   end

   always @(negedge clk) if (t_m_valid === 1'b1) t_mv_seen <= 1'b1;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic put(input logic [31:0] d);
      int n = 0;
      s_data  = d;
      s_valid = 1'b1;
      while (((sel_to ? t_s_ready : s_ready) !== 1'b1) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("put_timeout", 0, 1);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic send_block(input logic [127:0] k, input logic [63:0] t,
                             input logic [63:0] p, input bit stall);
      logic [31:0] w[8];
      logic [63:0] ct;
      w = '{k[127:96], k[95:64], k[63:32], k[31:0], t[63:32], t[31:0], p[63:32], p[31:0]};
      if (!sel_to) begin
         ct = cipher(k, t, p);
         sb_q.push_back(ct[63:32]);
         sb_q.push_back(ct[31:0]);
      end
      for (int i = 0; i < 8; i++) begin
         put(w[i]);
         if (stall && i < 7) begin
            @(negedge clk);
            chk("widx_hold", {125'd0, dut.widx}, 128'(i + 1));
         end
      end
   endtask

   // Counts PRIME cycles (busy with core reset held) from the cycle after the last word
   task automatic prime_len(output int n);
      n = 0;
      while ((sel_to ? (t_busy && !t_core_rst_n) : (busy && !core_rst_n)) && n < 10) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic recv_word();
      int n = 0;
      logic [31:0] exp;
      while (m_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("m_valid_up", {127'd0, m_valid}, 1);
      if (sb_q.size() == 0) begin
         chk("sb_underflow", 1, 0);
         exp = '0;
      end else exp = sb_q.pop_front();
      chk("m_data", {96'd0, m_data}, {96'd0, exp});
      @(negedge clk);
   endtask

   task automatic recv_block();
      recv_word();
      recv_word();
      chk("m_valid_drop", {127'd0, m_valid}, 0);
      chk("s_ready_b2b", {127'd0, s_ready}, 1);
   endtask

   task automatic chk_reset_outs(input bit in_rst);
      chk("rst_s_ready", {127'd0, s_ready}, in_rst ? 0 : 1);
      chk("rst_m_valid", {127'd0, m_valid}, 0);
      chk("rst_m_data", {96'd0, m_data}, 0);
      chk("rst_core_rst_n", {127'd0, core_rst_n}, 0);
      chk("rst_busy", {127'd0, busy}, 0);
      chk("rst_err", {127'd0, err}, 0);
      chk("rst_key", core_key, 0);
      chk("rst_pt_tw", {core_tweak, core_plaintext}, 0);
      chk("rst_ct_q", {64'd0, dut.ct_q}, 0);
      chk("rst_widx", {125'd0, dut.widx}, 0);
   endtask

   localparam logic [127:0] K0 = 128'h27A6781A43F364BC916708D5FBB5AEB1;
   localparam logic [63:0]  T0 = 64'h54CD94FFD0670A58;
   localparam logic [63:0]  P0 = 64'h5734F006D8D88A3E;

   initial begin
      int n;
      rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1; sel_to = 1'b0; t_mv_seen = 1'b0;
      @(negedge clk); @(negedge clk);
      chk_reset_outs(1'b1);
      rst = 1'b0;
      #1;
      chk_reset_outs(1'b0);

      // single block
      send_block(K0, T0, P0, 1'b0);
      prime_len(n);
      chk("prime_len", 128'(n), 2);
      chk("done_first_run", {127'd0, core_done}, 0);
      chk("key_loaded", core_key, K0);
      recv_block();

      // input stalls
      send_block(K0, T0, P0, 1'b1);
      prime_len(n);
      chk("prime_len_stall", 128'(n), 2);
      recv_block();

      // output backpressure
      m_ready = 1'b0;
      send_block(K0, T0, P0 ^ 64'h1, 1'b0);
      n = 0;
      while (m_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", {127'd0, m_valid}, 1);
         chk("bp_data", {96'd0, m_data}, {96'd0, (sb_q.size() > 0) ? sb_q[0] : 32'h0});
         @(negedge clk);
      end
      m_ready = 1'b1;
      recv_block();

      // back-to-back blocks, second with its own key/tweak/pt
      send_block(K0, T0, 64'h0123456789ABCDEF, 1'b0);
      recv_block();
      send_block(~K0, 64'hFEDCBA9876543210, 64'hDEADBEEF00C0FFEE, 1'b0);
      chk("key_b2", core_key, ~K0);
      chk("tweak_b2", {64'd0, core_tweak}, {64'd0, 64'hFEDCBA9876543210});
      recv_block();

      // timeout on the TIMEOUT=8 instance whose core never finishes
      sel_to = 1'b1;
      send_block(K0, T0, P0, 1'b0);
      prime_len(n);
      chk("to_prime_len", 128'(n), 2);
      n = 0;
      while (t_busy && n < 50) begin
         if (t_core_rst_n) n++;
         @(negedge clk);
      end
      chk("to_run_cycles", 128'(n), 8);
      chk("to_err", {127'd0, t_err}, 1);
      chk("to_back_load", {126'd0, t_busy, t_s_ready}, 1);
      repeat (5) @(negedge clk);
      chk("to_err_sticky", {127'd0, t_err}, 1);
      sel_to = 1'b0;

      // reset during RUN, then a fresh block
      send_block(K0, T0, P0, 1'b0);
      prime_len(n);
      repeat (5) @(negedge clk);
      chk("mid_run", {127'd0, core_rst_n}, 1);
      rst = 1'b1;
      #1;
      chk_reset_outs(1'b1);
      chk("to_err_cleared", {127'd0, t_err}, 0);
      sb_q.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_reset_outs(1'b0);
      send_block(K0 ^ 128'h5A, T0, P0 ^ 64'hA5, 1'b0);
      prime_len(n);
      chk("prime_len_after_rst", 128'(n), 2);
      recv_block();

      chk("to_m_valid_never", {127'd0, t_mv_seen}, 0);
      chk("sb_drained", 128'(sb_q.size()), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/craft_stream_loader.md
# craft_stream_loader

Bus-side front end for the CRAFT encryption core. It collects key, tweak and plaintext as a 32-bit valid/ready word stream and primes the core by holding the core's synchronous active-low reset for two cycles. It then waits for the core's `done`, captures the ciphertext, and returns it as two 32-bit words on a valid/ready output stream. It sits directly upstream of the core and also consumes what the core produces, so software sees one block per 8-words-in / 2-words-out transaction.

## Interface

Parameters:
- `TIMEOUT`, default 64: maximum cycles in RUN without `core_done` before the block aborts.

Ports:
- `clk` in 1: the single clock. Everything is clocked on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `s_valid` in 1: input word valid.
- `s_ready` out 1: input word ready. High only in LOAD.
- `s_data` in 32: input word.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: output word accepted.
- `m_data` out 32: output word.
- `core_rst_n` out 1: drives the core's `rst_n`.
- `core_plaintext` out 64: to the core, registered.
- `core_tweak` out 64: to the core, registered.
- `core_key` out 128: to the core, registered.
- `core_done` in 1: the core's `done`.
- `core_ciphertext` in 64: the core's `ciphertext`.
- `busy` out 1: high in any state other than LOAD.
- `err` out 1: sticky timeout flag. Cleared only by `rst`.

## Operation

Input word order (word index 0..7):
- Words 0–3: `key[127:96]`, `key[95:64]`, `key[63:32]`, `key[31:0]`.
- Words 4–5: `tweak[63:32]`, `tweak[31:0]`.
- Words 6–7: `plaintext[63:32]`, `plaintext[31:0]`.

A word transfers when `s_valid && s_ready` at a rising edge. A 3-bit `widx` counter selects the destination register slice.

State machine:
- **LOAD**
  - `s_ready`=1, `core_rst_n`=0.
  - Each transfer writes its slice and increments `widx`.
  - The transfer with `widx`=7 resets `widx` to 0 and moves to PRIME.
- **PRIME**
  - `core_rst_n`=0 for exactly 2 cycles, counted by a 1-bit counter.
  - Two cycles guarantees the core reloads `state` from `core_plaintext` and clears any stale `done`.
  - Then moves to RUN.
- **RUN**
  - `core_rst_n`=1. A timeout counter starts at 0 and increments each cycle.
  - If `core_done`=1 at an edge: latch `core_ciphertext` into `ct_q` and go to OUT_HI.
  - Else if the counter equals `TIMEOUT`-1: set `err` and go to LOAD. No output is produced.
- **OUT_HI**
  - `m_valid`=1, `m_data`=`ct_q[63:32]`.
  - On `m_ready`, go to OUT_LO.
- **OUT_LO**
  - `m_valid`=1, `m_data`=`ct_q[31:0]`.
  - On `m_ready`, go to LOAD.

Rules:
- `core_rst_n` is 0 in every state except RUN, OUT_HI and OUT_LO.
- After done, the core freezes its state, so `core_rst_n` stays 1 until the next PRIME.
- Key, tweak and plaintext registers hold their values outside LOAD.
- Each block requires a full 8-word reload. There is no partial key reuse.
- `m_data` and `m_valid` must not change while `m_valid`=1 and `m_ready`=0.
- `s_valid` while not in LOAD is ignored, because `s_ready`=0.

## Timing

Reset values, while `rst`=1 and immediately after it deasserts:
- State is LOAD, `widx`=0.
- `s_ready`=0 while `rst` is asserted, then 1 once in LOAD.
- `m_valid`=0, `m_data`=0, `core_rst_n`=0, `busy`=0, `err`=0.
- All data registers and `ct_q` are 0.

Latency:
- Minimum 8 cycles to load.
- PRIME is 2 cycles.
- RUN lasts until the core's `done`, about 32–34 cycles for 32 rounds.
- Then 1 cycle to present OUT_HI.
- With `m_ready` held at 1, `m_valid` is high for exactly 2 consecutive cycles.

Boundary conditions:
- **`s_valid` gaps in LOAD:** `widx` holds. There is no timeout in LOAD.
- **`core_done` already 1 on the first RUN cycle:** cannot occur because of the 2-cycle PRIME. Verification asserts this.
- **`rst` asserted in any state:** asynchronous return to LOAD. `widx` is cleared and any partial load or unsent ciphertext is discarded.
- **`m_ready` held 0:** the block stalls indefinitely in OUT_HI or OUT_LO.
- **Back-to-back blocks:** LOAD is re-entered the cycle after the OUT_LO handshake, and `s_ready` rises that cycle.

## Test plan

- **Single block.** Load key=`0x27A6781A43F364BC916708D5FBB5AEB1`, tweak=`0x54CD94FFD0670A58`, pt=`0x5734F006D8D88A3E`, with `m_ready`=1. Required: two `m_data` words equal to the golden model ciphertext, high word first, and `core_rst_n` low for exactly 2 cycles before RUN.
- **Input stalls.** Load the same block with `s_valid` toggling 1-0-1-0. Required: identical ciphertext, and `widx` advances only on handshakes.
- **Output backpressure.** Hold `m_ready`=0 for 10 cycles in OUT_HI. Required: `m_valid`=1 and `m_data` stable at the high word throughout, then both words delivered in order.
- **Back-to-back blocks.** Send two blocks with different plaintexts. Required: two correct ciphertexts, and the second block's key and tweak are taken from its own words.
- **Timeout.** With `TIMEOUT`=8 and `core_done` tied 0 in the bench. Required: `err`=1 after 8 RUN cycles, return to LOAD, and `m_valid` never asserted.
- **Reset mid-operation.** Assert `rst` for 1 cycle during RUN, then load a fresh block. Required: every output at its reset value, `err`=0, and the new block produces the correct ciphertext.
